nucl_sampler: RTL

// - Write-side counterpart of the per-site row-select PE. The PE reads a packed parent word
//   (16 x 2-bit nucleotides) and emits one 40-bit transition-matrix row per site.
// - This block takes one selected row plus one uniform random number per site, samples the

---
 rtl/nucl_sampler_if.sv | 36 +++
 rtl/nucl_sampler.sv | 126 ++++++++++++
 2 files changed

// File: rtl/nucl_sampler_if.sv
`default_nettype none
// ============================================================================
// Module      : nucl_sampler_if
// Description : Site-row input stream and packed-word output stream of the
//               nucleotide sampler.
// Revision    : 1.0 - initial release
// ============================================================================
interface nucl_sampler_if #(
    parameter int SITES  = 16,
    parameter int PROB_W = 10
);
    localparam int CNT_W = $clog2(SITES + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [4*PROB_W-1:0]   in_row;
    logic [PROB_W-1:0]     in_rand;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*SITES-1:0]    out_nucl_alig;
    logic [CNT_W-1:0]      out_count;

    // Producer of site rows and consumer of packed words
    modport master (
        output in_valid, in_row, in_rand, in_last, out_ready,
        input  in_ready, out_valid, out_nucl_alig, out_count
    );

    // The sampler itself
    modport slave (
        input  in_valid, in_row, in_rand, in_last, out_ready,
        output in_ready, out_valid, out_nucl_alig, out_count
    );
endinterface
`default_nettype wire

// File: rtl/nucl_sampler.sv
`default_nettype none
// ============================================================================
// Module      : nucl_sampler
// Description : Samples one child nucleotide per site from a transition row
//               and a uniform random number; packs SITES samples per word.
// Revision    : 1.0 - initial release
// ============================================================================
module nucl_sampler #(
    parameter int SITES  = 16,
    parameter int PROB_W = 10
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    nucl_sampler_if.slave    bus
);
    localparam int PTR_W  = $clog2(SITES);
    localparam int CNT_W  = $clog2(SITES + 1);
    localparam int WORD_W = 2 * SITES;
    localparam int SUM_W  = PROB_W + 2;

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [WORD_W-1:0]   pack_q, pack_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic [SUM_W-1:0]    w_c0, w_c1, w_c2, w_r;
    logic [1:0]          w_nucl;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_close;
    logic                w_handshake;
    logic [PTR_W:0]      w_bitpos;
    logic [WORD_W-1:0]   w_pack_ins;

    // Cumulative thresholds; p3 only fills whatever range is left above c2
    assign w_c0 = SUM_W'(bus.in_row[4*PROB_W-1:3*PROB_W]);
    assign w_c1 = w_c0 + SUM_W'(bus.in_row[3*PROB_W-1:2*PROB_W]);
    assign w_c2 = w_c1 + SUM_W'(bus.in_row[2*PROB_W-1:PROB_W]);
    assign w_r  = SUM_W'(bus.in_rand);

    always_comb begin
        w_nucl = 2'b11;
        if (w_r < w_c0) begin
            w_nucl = 2'b00;
        end else if (w_r < w_c1) begin
            w_nucl = 2'b01;
        end else if (w_r < w_c2) begin
            w_nucl = 2'b10;
        end
    end

    assign w_in_ready  = (state_q == S_FILL) || bus.out_ready;
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_handshake = (state_q == S_HOLD) && bus.out_ready;
    assign w_close     = w_accept && ((ptr_q == PTR_W'(SITES - 1)) || bus.in_last);
    assign w_bitpos    = {ptr_q, 1'b0};

    always_comb begin
        w_pack_ins                = pack_q;
        w_pack_ins[w_bitpos +: 2] = w_nucl;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        pack_d  = pack_q;
        word_d  = word_q;
        count_d = count_q;

        if (w_accept) begin
            if (w_close) begin
                ptr_d   = '0;
                pack_d  = '0;
                word_d  = w_pack_ins;
                count_d = CNT_W'(ptr_q) + CNT_W'(1);
            end else begin
                ptr_d   = ptr_q + PTR_W'(1);
                pack_d  = w_pack_ins;
            end
        end

        // A word closing in the handshake cycle keeps the output occupied
        case (state_q)
            S_FILL: begin
                if (w_close) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_handshake && !w_close) begin
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FILL;
            ptr_q   <= '0;
            pack_q  <= '0;
            word_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pack_q  <= pack_d;
            word_q  <= word_d;
            count_q <= count_d;
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = (state_q == S_HOLD);
    assign bus.out_nucl_alig = word_q;
    assign bus.out_count     = count_q;

endmodule
`default_nettype wire
